// File: rtl/bus_arb3x16_if.sv
// Bundle of request, data and grant/result signals for the 3-source shared-bus arbiter.
// The master side drives requests and source data; the slave side is the arbiter.
interface bus_arb3x16_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       req;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [2:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;

  modport master (
    output req, din0, din1, din2,
    input  gnt, sel, dout, dout_valid, busy
  );

  modport slave (
    input  req, din0, din1, din2,
    output gnt, sel, dout, dout_valid, busy
  );
endinterface

// File: rtl/bus_arb3x16.sv
// Round-robin arbiter and sequencer for a shared 16-bit 3:1 datapath mux.
// Grants one source at a time, bounds grants under contention, registers the selected word.
module bus_arb3x16 #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arb3x16_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_0    = 2'd0,
    OWN_1    = 2'd1,
    OWN_2    = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  localparam logic [3:0] HOLD_SAT = 4'(MAX_HOLD - 1);

  owner_t           r_owner;
  logic [1:0]       r_last;
  logic [3:0]       r_hold;
  logic [2:0]       r_gnt;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;

  owner_t           w_next_owner;
  logic [2:0]       w_next_gnt;
  logic [1:0]       w_next_sel;
  logic [1:0]       w_start;
  logic [2:0]       w_owner_mask;
  logic [2:0]       w_others;
  logic             w_keep;
  logic             w_xfer;
  logic [WIDTH-1:0] w_din;

  // First requester in circular order beginning at 'start'.
  function automatic owner_t rr_pick(input logic [2:0] m, input logic [1:0] start);
    owner_t      p;
    int unsigned t;
    p = OWN_NONE;
    for (int unsigned k = 0; k < 3; k++) begin
      t = int'(start) + k;
      if (t >= 3) t = t - 3;
      if (p == OWN_NONE && m[t]) p = owner_t'(t[1:0]);
    end
    return p;
  endfunction

  always_comb begin
    w_start      = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_owner_mask = (r_owner == OWN_NONE) ? 3'b000 : (3'b001 << r_owner);
    w_others     = bus.req & ~w_owner_mask;
    w_keep       = 1'b0;
    w_next_owner = OWN_NONE;
    if (r_owner == OWN_NONE) begin
      w_next_owner = rr_pick(bus.req, w_start);
    end else begin
      w_keep = (|(bus.req & w_owner_mask)) && !((r_hold == HOLD_SAT) && (|w_others));
      // The current owner is masked out, so a same-cycle re-raise cannot win it back.
      w_next_owner = w_keep ? r_owner : rr_pick(w_others, w_start);
    end
    w_next_gnt = (w_next_owner == OWN_NONE) ? 3'b000 : (3'b001 << w_next_owner);
    w_next_sel = (w_next_owner == OWN_NONE) ? 2'd0 : w_next_owner;
  end

  always_comb begin
    w_xfer = |(r_gnt & bus.req);
    case (r_sel)
      2'd1:    w_din = bus.din1;
      2'd2:    w_din = bus.din2;
      default: w_din = bus.din0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
      r_last  <= 2'd2;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_owner <= w_next_owner;
      r_gnt   <= w_next_gnt;
      r_sel   <= w_next_sel;
      if (w_next_owner != r_owner) begin
        r_hold <= '0;
        if (w_next_owner != OWN_NONE) r_last <= w_next_owner;
      end else if (w_xfer && r_hold != HOLD_SAT) begin
        r_hold <= r_hold + 4'd1;
      end
      r_valid <= w_xfer;
      if (w_xfer) r_dout <= w_din;
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.sel        = r_sel;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.busy       = |r_gnt;

endmodule
